// File: rtl/ff_sig_capture.sv
// Flop-bank signature capture: folds a 72-bit response into a 32-bit MISR
// over a fixed window. Define FF_SIG_TOGCOV_EN to add per-bit toggle coverage.
module ff_sig_capture #(
  parameter int          CYCLES = 64,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic        C,
  input  logic        R,
  input  logic        START,
  input  logic [71:0] Q_IN,
  output logic [31:0] SIG,
  output logic [7:0]  CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic [71:0] TOG
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(CYCLES - 1);

  state_t      state;
  state_t      nxt;
  logic        start_win;
  logic        step;
  logic [31:0] fold;
  logic [31:0] misr_nxt;

  assign fold = Q_IN[31:0] ^ Q_IN[63:32]
              ^ {24'b0, Q_IN[71:64]};

  assign misr_nxt = {SIG[30:0], 1'b0}
                  ^ (SIG[31] ? POLY : 32'b0)
                  ^ fold;

  // Next-state decode; START is only honoured outside RUN.
  always_comb begin
    nxt       = state;
    start_win = 1'b0;
    step      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          nxt       = S_RUN;
          start_win = 1'b1;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (CNT == LAST)
          nxt = S_DONE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge C) begin
    if (R) begin
      state <= S_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= nxt;
      BUSY  <= (nxt == S_RUN);
      DONE  <= (nxt == S_DONE);
    end
  end

  // MISR and sample counter; both frozen outside RUN.
  always_ff @(posedge C) begin
    if (R) begin
      SIG <= 32'b0;
      CNT <= 8'b0;
    end else if (start_win) begin
      SIG <= SEED;
      CNT <= 8'b0;
    end else if (step) begin
      SIG <= misr_nxt;
      CNT <= CNT + 8'd1;
    end
  end

`ifdef FF_SIG_TOGCOV_EN
  logic [71:0] prev;

  // Toggle accumulation, starting from the second sample of a window.
  always_ff @(posedge C) begin
    if (R) begin
      prev <= 72'b0;
      TOG  <= 72'b0;
    end else if (start_win) begin
      TOG <= 72'b0;
    end else if (step) begin
      prev <= Q_IN;
      if (CNT != 8'd0)
        TOG <= TOG | (Q_IN ^ prev);
    end
  end
`else
  assign TOG = 72'b0;
`endif

endmodule

// File: tb/tb_ff_sig_capture.sv
// Directed bench for ff_sig_capture: three instances with
// different window lengths/seeds share one stimulus stream.
module tb_ff_sig_capture;

  logic        C;
  logic        R;
  logic        START;
  logic [71:0] Q_IN;

  logic [31:0] s1, s2, s3;
  logic [7:0]  c1, c2, c3;
  logic        b1, b2, b3;
  logic        d1, d2, d3;
  logic [71:0] t1, t2, t3;

  int n_chk;
  int n_fail;

  ff_sig_capture #(.CYCLES(1), .SEED(32'h0)) u1 (
    .C(C), .R(R), .START(START), .Q_IN(Q_IN),
    .SIG(s1), .CNT(c1), .BUSY(b1), .DONE(d1), .TOG(t1)
  );

  ff_sig_capture #(.CYCLES(2), .SEED(32'h80000000)) u2 (
    .C(C), .R(R), .START(START), .Q_IN(Q_IN),
    .SIG(s2), .CNT(c2), .BUSY(b2), .DONE(d2), .TOG(t2)
  );

  ff_sig_capture u3 (
    .C(C), .R(R), .START(START), .Q_IN(Q_IN),
    .SIG(s3), .CNT(c3), .BUSY(b3), .DONE(d3), .TOG(t3)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [71:0] obs,
                     input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mstep(input logic [31:0] s,
                                        input logic [71:0] q);
    logic [31:0] f;
    f = q[31:0] ^ q[63:32] ^ {24'b0, q[71:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  task automatic do_reset();
    R = 1'b1;
    tick();
    R = 1'b0;
  endtask

  logic [31:0] sig_m;
  logic [71:0] tog_exp;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    R      = 1'b0;
    START  = 1'b0;
    Q_IN   = 72'h0;

    // Reset state
    do_reset();
    chk("rst_sig", 72'(s3), 72'h0);
    chk("rst_cnt", 72'(c3), 72'h0);
    chk("rst_busy", 72'(b3), 72'h0);
    chk("rst_done", 72'(d3), 72'h0);
    chk("rst_tog", t3, 72'h0);

    // CYCLES=1, SEED=0, Q_IN=1
    Q_IN  = 72'h1;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("c1_busy", 72'(b1), 72'h1);
    chk("c1_sig0", 72'(s1), 72'h0);
    chk("c1_cnt0", 72'(c1), 72'h0);
    tick();
    chk("c1_done", 72'(d1), 72'h1);
    chk("c1_nbusy", 72'(b1), 72'h0);
    chk("c1_sig", 72'(s1), 72'h1);
    chk("c1_cnt", 72'(c1), 72'h1);
    Q_IN = 72'hFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    chk("c1_hold_sig", 72'(s1), 72'h1);
    chk("c1_hold_cnt", 72'(c1), 72'h1);

    // Fold cancellation: bits 0 and 32
    do_reset();
    Q_IN  = 72'h00_0000_0001_0000_0001;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("fold_done", 72'(d1), 72'h1);
    chk("fold_sig", 72'(s1), 72'h0);

    // CYCLES=2, SEED=80000000, Q_IN=0
    do_reset();
    Q_IN  = 72'h0;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("c2_notdone", 72'(d2), 72'h0);
    chk("c2_mid_sig", 72'(s2), 72'h04C11DB7);
    tick();
    chk("c2_done", 72'(d2), 72'h1);
    chk("c2_sig", 72'(s2), 72'h09823B6E);
    chk("c2_cnt", 72'(c2), 72'h2);

    // START held through RUN and DONE: back-to-back windows
    do_reset();
    START = 1'b1;
    tick();
    chk("b2b_busy0", 72'(b2), 72'h1);
    chk("b2b_cnt0", 72'(c2), 72'h0);
    tick();
    chk("b2b_cnt1", 72'(c2), 72'h1);
    tick();
    chk("b2b_done", 72'(d2), 72'h1);
    chk("b2b_cnt2", 72'(c2), 72'h2);
    tick();
    chk("b2b_restart", 72'(b2), 72'h1);
    chk("b2b_recnt", 72'(c2), 72'h0);
    tick();
    tick();
    chk("b2b_done2", 72'(d2), 72'h1);
    chk("b2b_cnt2b", 72'(c2), 72'h2);
    START = 1'b0;

    // Reset and START at the same edge: reset wins
    R     = 1'b1;
    START = 1'b1;
    tick();
    R     = 1'b0;
    START = 1'b0;
    chk("rw_busy", 72'(b1), 72'h0);
    chk("rw_done", 72'(d1), 72'h0);
    tick();
    chk("rw_idle", 72'(b1), 72'h0);

    // Default window aborted at sample 10
    do_reset();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 10; i++) begin
      Q_IN = {8'($urandom), $urandom, $urandom};
      tick();
    end
    chk("ab_cnt10", 72'(c3), 72'd10);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("ab_busy", 72'(b3), 72'h0);
    chk("ab_sig", 72'(s3), 72'h0);
    chk("ab_cnt", 72'(c3), 72'h0);

    // Full 64-sample window with random data
    START = 1'b1;
    tick();
    START = 1'b0;
    sig_m = 32'hFFFFFFFF;
    chk("full_seed", 72'(s3), 72'(sig_m));
    for (int i = 0; i < 63; i++) begin
      Q_IN  = {8'($urandom), $urandom, $urandom};
      sig_m = mstep(sig_m, Q_IN);
      tick();
    end
    chk("full_busy63", 72'(b3), 72'h1);
    chk("full_cnt63", 72'(c3), 72'd63);
    Q_IN  = {8'($urandom), $urandom, $urandom};
    sig_m = mstep(sig_m, Q_IN);
    tick();
    chk("full_done", 72'(d3), 72'h1);
    chk("full_cnt", 72'(c3), 72'd64);
    chk("full_sig", 72'(s3), 72'(sig_m));
    for (int i = 0; i < 3; i++) begin
      Q_IN = {8'($urandom), $urandom, $urandom};
      tick();
    end
    chk("full_hold_cnt", 72'(c3), 72'd64);
    chk("full_hold_sig", 72'(s3), 72'(sig_m));

    // Toggle coverage: 0 / FF alternating for 4 samples
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("tog_clear", t3, 72'h0);
    for (int i = 0; i < 4; i++) begin
      Q_IN = (i % 2 == 0) ? 72'h0 : 72'hFF;
      tick();
    end
`ifdef FF_SIG_TOGCOV_EN
    tog_exp = 72'hFF;
`else
    tog_exp = 72'h0;
`endif
    chk("tog_val", t3, tog_exp);
    chk("tog_cnt", 72'(c3), 72'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
